// File: rtl/ram_stream_reader_pkg.sv
// rtl/ram_stream_reader_pkg.sv - shared FSM encoding and buffer sizing for the RAM stream reader
// Purpose: state type and output-buffer depth shared by ram_stream_reader and ram_stream_skid.
// Ports: none (package).
package ram_stream_reader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } rsr_state_t;

   localparam int RSR_BUF_DEPTH = 2;

endpackage

// File: rtl/ram_stream_skid.sv
// rtl/ram_stream_skid.sv - two-entry FIFO with registered head output
// Purpose: small output buffer for stream blocks; head entry drives the stream directly.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   push, din       write one entry
//   pop             remove the head entry (ignored when empty)
//   head, valid     head entry data and presence flag
//   count           number of stored entries, 0..2
module ram_stream_skid
   import ram_stream_reader_pkg::*;
#(
   parameter int Data_Width = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic [Data_Width-1:0] din,
   input  logic                  pop,
   output logic [Data_Width-1:0] head,
   output logic                  valid,
   output logic [1:0]            count
);

   logic [Data_Width-1:0] entry0;
   logic [Data_Width-1:0] entry1;
   logic [1:0]            cnt;
   logic                  do_pop;
   logic                  do_push;

   assign do_pop  = pop && (cnt != 2'd0);
   // A push into a full buffer is only accepted when the head leaves in the same cycle.
   assign do_push = push && ((cnt != 2'(RSR_BUF_DEPTH)) || do_pop);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         entry0 <= '0;
         entry1 <= '0;
         cnt    <= 2'd0;
      end else begin
         case ({do_push, do_pop})
            2'b10: begin
               if (cnt == 2'd0) entry0 <= din;
               else             entry1 <= din;
               cnt <= cnt + 2'd1;
            end
            2'b01: begin
               entry0 <= entry1;
               cnt    <= cnt - 2'd1;
            end
            2'b11: begin
               if (cnt == 2'd1) begin
                  entry0 <= din;
               end else begin
                  entry0 <= entry1;
                  entry1 <= din;
               end
            end
            default: ;
         endcase
      end
   end

   assign head  = entry0;
   assign valid = (cnt != 2'd0);
   assign count = cnt;

endmodule

// File: rtl/ram_stream_reader.sv
// rtl/ram_stream_reader.sv - sweeps a block of RAM words out as a valid/ready stream
// Purpose: on start, reads length words from base_addr upward (wrapping) through a
//          synchronous RAM read port and streams them in address order.
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   start, base_addr, length       sweep request, captured only in IDLE
//   Re_addr, Data_read             RAM read port (data one cycle after address)
//   dout, dout_valid, dout_ready   output stream
//   busy, done                     sweep in progress / one-cycle completion pulse
module ram_stream_reader
   import ram_stream_reader_pkg::*;
#(
   parameter int Data_Width = 8,
   parameter int Addr_Width = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [Addr_Width-1:0] base_addr,
   input  logic [Addr_Width:0]   length,
   output logic [Addr_Width-1:0] Re_addr,
   input  logic [Data_Width-1:0] Data_read,
   output logic [Data_Width-1:0] dout,
   output logic                  dout_valid,
   input  logic                  dout_ready,
   output logic                  busy,
   output logic                  done
);

   localparam logic [Addr_Width:0] ONE_WORD = {{Addr_Width{1'b0}}, 1'b1};

   rsr_state_t            state;
   rsr_state_t            state_nxt;
   logic [Addr_Width-1:0] next_addr;
   logic [Addr_Width-1:0] last_addr;
   logic [Addr_Width:0]   issue_rem;
   logic [Addr_Width:0]   word_rem;
   logic                  in_flight;
   logic                  issue;
   logic                  pop;
   logic [1:0]            buf_count;
   logic [1:0]            occupancy;

   assign pop = dout_valid && dout_ready;

   // Entries that will still be owed buffer space after this cycle: the read in
   // flight plus what stays buffered once the current head has left. Counting the
   // departing head as free space is what lets the sweep sustain one word per cycle.
   assign occupancy = {1'b0, in_flight} + buf_count - {1'b0, pop};
   assign issue     = (state == ST_READ) && (occupancy < 2'(RSR_BUF_DEPTH));

   // The address is presented in the issue cycle itself so the RAM's registered
   // read lands one cycle later; otherwise it holds the last issued address.
   assign Re_addr = issue ? next_addr : last_addr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         next_addr <= '0;
         last_addr <= '0;
         issue_rem <= '0;
         word_rem  <= '0;
         in_flight <= 1'b0;
      end else begin
         state     <= state_nxt;
         // Read data for an issued address is present on the following cycle and is pushed then.
         in_flight <= issue;
         if ((state == ST_IDLE) && start) begin
            next_addr <= base_addr;
            issue_rem <= length;
            word_rem  <= length;
         end
         if (issue) begin
            last_addr <= next_addr;
            next_addr <= next_addr + 1'b1;
            issue_rem <= issue_rem - ONE_WORD;
         end
         if (pop) begin
            word_rem <= word_rem - ONE_WORD;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = (length == '0) ? ST_DONE : ST_READ;
            end
         end
         ST_READ: begin
            busy = 1'b1;
            if (issue && (issue_rem == ONE_WORD)) state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            busy = 1'b1;
            if (pop && (word_rem == ONE_WORD)) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   ram_stream_skid #(
      .Data_Width(Data_Width)
   ) u_skid (
      .clk   (clk),
      .reset (reset),
      .push  (in_flight),
      .din   (Data_read),
      .pop   (pop),
      .head  (dout),
      .valid (dout_valid),
      .count (buf_count)
   );

endmodule

// File: tb/tb_ram_stream_reader.sv
// tb/tb_ram_stream_reader.sv - scoreboard bench for ram_stream_reader with a synchronous RAM model
module tb_ram_stream_reader;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [1:0] base_addr = '0;
   logic [2:0] length = '0;
   logic [1:0] Re_addr;
   logic [7:0] Data_read;
   logic [7:0] dout;
   logic       dout_valid;
   logic       dout_ready = 1'b1;
   logic       busy;
   logic       done;

   logic       wr_en = 1'b0;
   logic [1:0] wr_addr = '0;
   logic [7:0] wr_data = '0;
   logic [7:0] ram [4];
   logic [7:0] ref_mem [4];

   logic [7:0] exp_q [$];
   int         n_vec = 0;
   int         n_fail = 0;

   always #5 clk = ~clk;

   // Dual-port RAM: one write port, registered read port.
   always @(posedge clk) begin
      if (wr_en) ram[wr_addr] <= wr_data;
      Data_read <= ram[Re_addr];
   end

   ram_stream_reader #(.Data_Width(8), .Addr_Width(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .base_addr  (base_addr),
      .length     (length),
      .Re_addr    (Re_addr),
      .Data_read  (Data_read),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .busy       (busy),
      .done       (done)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops the expected word on every transfer and checks stall stability.
   logic       prev_stall = 1'b0;
   logic [7:0] prev_dout = '0;
   always @(negedge clk) begin
      if (reset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_valid_held", dout_valid, 1);
            check("stall_data_held", dout, prev_dout);
         end
         if (dout_valid && dout_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_word", 1, 0);
            end else begin
               check("stream_data", dout, exp_q.pop_front());
            end
         end
         prev_stall = dout_valid && !dout_ready;
         prev_dout  = dout;
      end
   end

   task automatic ram_write(input logic [1:0] a, input logic [7:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      @(posedge clk); #1;
      wr_en = 1'b0;
      ref_mem[a] = d;
   endtask

   // Issues a start from IDLE and queues the words the sweep must produce; returns just after the start edge.
   task automatic start_sweep(input logic [1:0] b, input logic [2:0] l);
      base_addr = b; length = l; start = 1'b1;
      for (int k = 0; k < int'(l); k++) exp_q.push_back(ref_mem[(int'(b) + k) % 4]);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input bit rnd, output int cycles);
      bit seen = 1'b0;
      cycles = 0;
      while (!seen && cycles < 100) begin
         @(posedge clk); #1;
         cycles++;
         if (done) seen = 1'b1;
         else if (rnd) dout_ready = 1'($urandom_range(0, 1));
      end
      check("done_seen", seen, 1);
      check("busy_low_in_done", busy, 0);
      check("all_words_delivered", exp_q.size(), 0);
      @(posedge clk); #1;
      check("done_single_cycle", done, 0);
      dout_ready = 1'b1;
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int cyc;
      int total;
      int ev [7];
      int ed [7];
      int eb [7];
      ev = '{0, 1, 1, 1, 1, 0, 0};
      ed = '{0, 0, 0, 0, 0, 1, 0};
      eb = '{1, 1, 1, 1, 1, 0, 0};

      repeat (3) @(posedge clk);
      #1;
      check("reset_re_addr", Re_addr, 0);
      check("reset_dout", dout, 0);
      check("reset_dout_valid", dout_valid, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      reset = 1'b0;

      ram_write(2'd0, 8'd6);
      ram_write(2'd1, 8'd5);
      ram_write(2'd2, 8'd4);
      ram_write(2'd3, 8'd3);

      // Full sweep with cycle-exact latency and done/busy timing.
      start_sweep(2'd0, 3'd4);
      check("full_busy_after_start", busy, 1);
      check("full_first_addr", Re_addr, 0);
      for (int i = 0; i < 7; i++) begin
         @(posedge clk); #1;
         check($sformatf("full_valid_c%0d", i + 1), dout_valid, ev[i]);
         check($sformatf("full_done_c%0d", i + 1), done, ed[i]);
         check($sformatf("full_busy_c%0d", i + 1), busy, eb[i]);
      end
      check("full_all_delivered", exp_q.size(), 0);

      // Wrap-around: addresses 3 then 0.
      start_sweep(2'd3, 3'd2);
      check("wrap_addr0", Re_addr, 3);
      @(posedge clk); #1;
      check("wrap_addr1", Re_addr, 0);
      wait_done(1'b0, cyc);

      // Backpressure: five stalled cycles, at most two reads issued.
      dout_ready = 1'b0;
      start_sweep(2'd1, 3'd3);
      repeat (5) begin
         @(posedge clk); #1;
      end
      check("stall_reads_bounded", Re_addr, 2);
      check("stall_head_valid", dout_valid, 1);
      check("stall_head_data", dout, 5);
      dout_ready = 1'b1;
      wait_done(1'b0, cyc);

      // Zero length: done right away, nothing streamed.
      start_sweep(2'd2, 3'd0);
      check("zero_done", done, 1);
      check("zero_busy", busy, 0);
      check("zero_valid", dout_valid, 0);
      @(posedge clk); #1;
      check("zero_done_clears", done, 0);
      check("zero_valid_after", dout_valid, 0);

      // Start pulsed mid-sweep must be ignored.
      start_sweep(2'd0, 3'd4);
      @(posedge clk); #1;
      base_addr = 2'd2; length = 3'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(1'b0, cyc);
      repeat (6) begin
         @(posedge clk); #1;
         check("ignored_start_idle", busy, 0);
      end

      // Reset between two words of a full sweep.
      start_sweep(2'd0, 3'd4);
      repeat (3) begin
         @(posedge clk); #1;
      end
      reset = 1'b1;
      #1;
      check("rst_mid_valid", dout_valid, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_done", done, 0);
      exp_q.delete();
      @(posedge clk); #1;
      reset = 1'b0;
      start_sweep(2'd2, 3'd1);
      wait_done(1'b0, cyc);
      repeat (4) @(posedge clk);
      #1;

      // Random ready over repeated full sweeps.
      total = 0;
      while (total < 200) begin
         start_sweep(2'd0, 3'd4);
         wait_done(1'b1, cyc);
         total += cyc + 2;
      end

      // Random contents, base, length and ready.
      for (int s = 0; s < 12; s++) begin
         ram_write(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
         start_sweep(2'($urandom_range(0, 3)), 3'($urandom_range(1, 4)));
         wait_done(1'b1, cyc);
      end

      repeat (4) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
